// File: rtl/data_bus_controller.sv
// Initiator side of the CPU data bus. It takes one load or store at a time, decodes the
// flash/RAM/IO window and sequences the bus, rejecting bad requests with a fault pulse.
module data_bus_controller #(
  parameter int unsigned FLASH_SIZE = 12288,
  parameter logic [31:0] RAM_BASE   = 32'h0001_0000,
  parameter int unsigned RAM_SIZE   = 4096,
  parameter logic [31:0] IO_BASE    = 32'h0002_0000,
  parameter int unsigned IO_SIZE    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        stall_lw,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [31:0] data_bus_addr,
  output logic [1:0]  data_bus_mode,
  output logic [1:0]  data_bus_reqw,
  output logic        data_bus_reqs,
  output logic [31:0] data_bus_wdata,
  output logic        data_bus_select_flash,
  output logic        data_bus_select_ram,
  output logic        data_bus_select_io,
  input  logic [31:0] data_bus_data
);

  localparam logic [31:0] FLASH_END = 32'(FLASH_SIZE);
  localparam logic [31:0] RAM_END   = RAM_BASE + 32'(RAM_SIZE);
  localparam logic [31:0] IO_END    = IO_BASE + 32'(IO_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_ADDR, S_LOAD_DATA, S_STORE} state_t;

  state_t      r_state, w_next;
  logic        r_done, r_fault, w_done_nxt, w_fault_nxt;
  logic [31:0] r_addr, r_wdata, r_load_data;
  logic [1:0]  r_reqw;
  logic        r_reqs;
  logic        w_req_flash, w_req_ram, w_req_io, w_req_bad;
  logic        w_lat_flash, w_lat_ram, w_lat_io;

  // Flash sits at 0, so only its upper bound needs checking.
  assign w_req_flash = req_addr < FLASH_END;
  assign w_req_ram   = (req_addr >= RAM_BASE) && (req_addr < RAM_END);
  assign w_req_io    = (req_addr >= IO_BASE) && (req_addr < IO_END);
  assign w_lat_flash = r_addr < FLASH_END;
  assign w_lat_ram   = (r_addr >= RAM_BASE) && (r_addr < RAM_END);
  assign w_lat_io    = (r_addr >= IO_BASE) && (r_addr < IO_END);

  assign w_req_bad = (req_width == 2'b11)
                   || ((req_width == 2'b00) && (req_addr[1:0] != 2'b00))
                   || ((req_width == 2'b01) && (req_addr[1:0] == 2'b11))
                   || !(w_req_flash || w_req_ram || w_req_io)
                   || (req_write && w_req_flash);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_reqw      <= '0;
      r_reqs      <= 1'b0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nxt;
      r_fault <= w_fault_nxt;
      if (r_state == S_IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_reqw  <= req_width;
        r_reqs  <= req_signed;
      end
      if (r_state == S_LOAD_DATA) r_load_data <= data_bus_data;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_done_nxt    = 1'b0;
    w_fault_nxt   = 1'b0;
    data_bus_mode = 2'b00;
    case (r_state)
      S_IDLE: if (req_valid) begin
        if (w_req_bad) w_fault_nxt = 1'b1;
        else           w_next = req_write ? S_STORE : S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        data_bus_mode = 2'b01;
        w_next        = S_LOAD_DATA;
      end
      S_LOAD_DATA: begin
        data_bus_mode = 2'b01;
        w_next        = S_IDLE;
        w_done_nxt    = 1'b1;
      end
      S_STORE: begin
        data_bus_mode = 2'b10;
        w_next        = S_IDLE;
        w_done_nxt    = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign stall_lw = (r_state == S_LOAD_ADDR);
  assign done     = r_done;
  assign fault    = r_fault;
  assign load_data      = r_load_data;
  assign data_bus_addr  = r_addr;
  assign data_bus_reqw  = r_reqw;
  assign data_bus_reqs  = r_reqs;
  assign data_bus_wdata = r_wdata;
  // Windows are disjoint, so at most one select can rise.
  assign data_bus_select_flash = busy && w_lat_flash;
  assign data_bus_select_ram   = busy && w_lat_ram;
  assign data_bus_select_io    = busy && w_lat_io;

endmodule

// File: doc/data_bus_controller.md
Name: data_bus_controller

Overview:
- Initiator side of the CPU data bus; the program flash, data RAM and IO block are its responders.
- Accepts one load/store request at a time from the execute stage and latches it.
- Decodes the target region and drives the shared data bus (addr, mode, width, sign, select).
- Sequences the two-cycle flash/RAM read (asserts stall_lw in the address cycle), returns load data, and flags misaligned, unmapped or illegal accesses.

Parameters:
- FLASH_SIZE, 12288: flash byte size. Flash window is 0x0 .. FLASH_SIZE-1.
- RAM_BASE, 32'h0001_0000: data RAM base byte address.
- RAM_SIZE, 4096: data RAM byte size.
- IO_BASE, 32'h0002_0000: IO window base byte address.
- IO_SIZE, 256: IO window byte size.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present; sampled only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_width  in  2  00 WORD, 01 HALF_WORD, 10 BYTE, 11 illegal
- req_signed  in  1  1 = sign-extend load result
- req_wdata  in  32  store data, right-aligned
- busy  out  1  controller not in IDLE; execute stage holds
- stall_lw  out  1  high in the load address cycle only
- done  out  1  one-cycle completion pulse
- load_data  out  32  registered load result, valid when done=1 and the op was a load
- fault  out  1  one-cycle pulse; request rejected, no bus side effects
- data_bus_addr  out  32  latched byte address
- data_bus_mode  out  2  00 idle, 01 read, 10 write
- data_bus_reqw  out  2  latched width
- data_bus_reqs  out  1  latched sign flag
- data_bus_wdata  out  32  latched store data
- data_bus_select_flash  out  1  flash selected
- data_bus_select_ram  out  1  RAM selected
- data_bus_select_io  out  1  IO selected
- data_bus_data  in  32  OR of responder outputs; an unselected responder drives 0

Behaviour:
Reset:
- State goes to IDLE.
- All outputs are 0, including load_data and the latched request registers.
- Reset mid-operation aborts the operation: no done, no fault.

States:
- IDLE
  - busy=0, mode=00, all selects 0.
  - On req_valid: latch addr, width, signed, wdata and write; classify the request.
  - Fault when any of these holds; next state IDLE with fault=1 next cycle:
    - width=11
    - WORD with addr[1:0]!=0
    - HALF_WORD with addr[1:0]==11
    - address in no window
    - store to flash
  - Otherwise: load goes to LOAD_ADDR, store goes to STORE.
- LOAD_ADDR
  - mode=01, region select=1, stall_lw=1, busy=1.
  - Next state LOAD_DATA unconditionally.
- LOAD_DATA
  - mode=01, select held, stall_lw=0, busy=1.
  - At the clock edge: load_data <= data_bus_data (the responder has already done width extraction and sign extension).
  - Next state IDLE; done=1 next cycle.
- STORE
  - mode=10, select=1, wdata, addr and reqw driven, busy=1, for exactly one cycle.
  - The responder commits the store at the edge that ends this cycle.
  - Next state IDLE; done=1 next cycle.

Region decode:
- Decode is on the latched address, using unsigned compares.
- A window is hit when base <= addr < base+size.
- Exactly one select can be high at a time.

Latency and timing:
- Load: request edge, then 2 cycles, then done. Total 3 cycles from req_valid in IDLE to done.
- Store: 2 cycles from request to done.
- Fault: 1 cycle from request to fault.
- done and fault are mutually exclusive and last one cycle, coincident with IDLE.
- A new request may be accepted in the same cycle done or fault is high.
- load_data holds its value until the next load completes; stores and faults do not change it.
- req_* is ignored while busy=1.

Test Plan:
- Word load at 0x0000_0010, flash model returns 0xDEADBEEF:
  - stall_lw=1 one cycle after accept, then mode=01 for 2 cycles.
  - done with load_data=0xDEADBEEF 3 cycles after accept.
  - select_flash=1 only.
- Signed byte load at RAM_BASE+3, RAM model returns 0xFFFFFF80:
  - data_bus_reqw=10, data_bus_reqs=1, addr=0x0001_0003.
  - load_data=0xFFFFFF80.
- Half-word store of 0x1234 to 0x0002_0004:
  - One cycle with mode=10, select_io=1, wdata=0x0000_1234, reqw=01.
  - done on the following cycle.
  - load_data unchanged.
- Fault cases; each gives fault=1 one cycle after accept, mode stays 00, no select, no done:
  - word load at 0x0001_0002
  - half load at 0x0001_0003
  - store to 0x0000_0100
  - load at 0x0003_0000
  - width=11
- Back-to-back requests:
  - Load request held, then a store presented in the done cycle: store is accepted immediately.
  - req_valid toggled while busy: ignored.
- Reset asserted during LOAD_DATA:
  - Next cycle: IDLE, busy=0, done=0, load_data=0, all bus outputs 0.
